// File: rtl/channel_data_pkg.sv
// Shared types and constants for the sTGC TDS readout merger.
package channel_data_pkg;

    localparam int TDS_DATA_W        = 120;
    localparam int DEFAULT_MAX_BURST = 16;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } merge_state_t;

    // Channel tag width; a single channel still carries a 1-bit tag.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotating-priority find-first: first set req bit at or above ptr, wrapping modulo N_CH.
module rr_arbiter_n
    import channel_data_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            hit,
    output logic [CH_W-1:0] idx
);

    logic [CH_W:0]   sum;
    logic [CH_W-1:0] cand;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        sum  = '0;
        cand = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum = {1'b0, ptr} + (CH_W+1)'(k);
            // Wrap with a subtract so non-power-of-2 N_CH never yields an index >= N_CH.
            if (sum >= (CH_W+1)'(N_CH)) begin
                sum = sum - (CH_W+1)'(N_CH);
            end
            cand = sum[CH_W-1:0];
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/channel_data_merge_n.sv
// N-channel round-robin burst merger from FWFT channel FIFOs onto one tagged valid/ready stream.
// Optional per-channel 32-bit pop counters are built when CHANNEL_WORD_CNT_EN is defined.
module channel_data_merge_n
    import channel_data_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DATA_W    = TDS_DATA_W,
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    localparam int CH_W     = ch_width(N_CH),
    localparam int BURST_W  = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk160,
    input  logic                     reset,
    input  logic                     tds_mode,
    input  logic [N_CH-1:0]          enable,
    input  logic [N_CH-1:0]          strip_linked,
    input  logic [N_CH-1:0]          pad_linked,
    input  logic [N_CH-1:0]          data_tran_stop,
    input  logic [N_CH-1:0]          channel_fifo_empty,
    input  logic [N_CH*DATA_W-1:0]   channel_data,
    output logic [N_CH-1:0]          channel_data_read,
    output logic [N_CH-1:0]          channel_linked,
`ifdef CHANNEL_WORD_CNT_EN
    input  logic                     cnt_clear,
    output logic [N_CH*32-1:0]       word_count,
`endif
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_channel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     dbg_state,
    output logic [CH_W-1:0]          dbg_rr_ptr
);

    // Output handshake: a word moves when out_valid & out_ready are both high at a
    // rising edge; out_valid never drops without a transfer and out_data is stable
    // while out_valid is high and out_ready is low.

    merge_state_t        state_q, state_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_channel_q, out_channel_d;

    logic [N_CH-1:0]     elig;
    logic                arb_hit;
    logic [CH_W-1:0]     arb_idx;
    logic                sel_elig;
    logic [DATA_W-1:0]   sel_word;
    logic                can_load;
    logic                pop;
    logic                burst_last;
    logic [CH_W-1:0]     next_ptr;

    assign channel_linked = tds_mode ? strip_linked : pad_linked;
    assign elig           = enable & channel_linked & ~channel_fifo_empty & ~data_tran_stop;
    assign can_load       = ~out_valid_q | out_ready;

    rr_arbiter_n #(
        .N_CH (N_CH)
    ) u_arb (
        .req (elig),
        .ptr (rr_ptr_q),
        .hit (arb_hit),
        .idx (arb_idx)
    );

    always_comb begin
        sel_elig = 1'b0;
        sel_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_q == CH_W'(i)) begin
                sel_elig = elig[i];
                sel_word = channel_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset masks the pop so the FIFOs are never drained while the merger is held.
    assign pop        = (state_q == BURST) && sel_elig && can_load && !reset;
    assign burst_last = (burst_cnt_q == BURST_W'(MAX_BURST - 1));
    assign next_ptr   = (sel_q == CH_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;

    always_comb begin
        channel_data_read = '0;
        for (int i = 0; i < N_CH; i++) begin
            channel_data_read[i] = pop && (sel_q == CH_W'(i));
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ARB: begin
                if (arb_hit) begin
                    sel_d       = arb_idx;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (pop) begin
                    out_valid_d   = 1'b1;
                    out_data_d    = sel_word;
                    out_channel_d = sel_q;
                    burst_cnt_d   = burst_cnt_q + 1'b1;
                    if (burst_last) begin
                        state_d  = ARB;
                        rr_ptr_d = next_ptr;
                    end
                end else if (!sel_elig) begin
                    // Channel lost eligibility; a mere output stall keeps the burst.
                    state_d  = ARB;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk160) begin
        if (reset) begin
            state_q       <= ARB;
            sel_q         <= '0;
            rr_ptr_q      <= '0;
            burst_cnt_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;
    assign dbg_state   = state_q;
    assign dbg_rr_ptr  = rr_ptr_q;

`ifdef CHANNEL_WORD_CNT_EN
    logic [31:0] cnt_q [N_CH];
    logic [31:0] cnt_d [N_CH];

    // Clear has priority over a same-cycle pop; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clear) begin
                cnt_d[i] = '0;
            end else if (channel_data_read[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
                cnt_d[i] = cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk160) begin
        for (int i = 0; i < N_CH; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_word_count
        assign word_count[g*32 +: 32] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_channel_data_merge_n.sv
// Directed bench for channel_data_merge_n: FIFO models, expected-word queue, one summary line.
module tb_channel_data_merge_n;
    import channel_data_pkg::*;

    localparam int N   = 4;
    localparam int W   = 120;
    localparam int CHW = 2;
    localparam int XW  = 128;

    // ---------------- clock / reset ----------------
    logic clk160 = 1'b0;
    always #5 clk160 = ~clk160;

    logic            reset;
    logic            tds_mode;
    logic            out_ready;
    logic            use_b;
    logic [N-1:0]    enable, strip_linked, pad_linked, data_tran_stop, fifo_empty;
    logic [N*W-1:0]  channel_data;
    logic [N-1:0]    empty_a, empty_b;

    logic [N-1:0]    read_a, read_b, linked_a, linked_b;
    logic [W-1:0]    out_data_a, out_data_b;
    logic [CHW-1:0]  out_channel_a, out_channel_b, rr_a, rr_b;
    logic            out_valid_a, out_valid_b, state_a, state_b;
`ifdef CHANNEL_WORD_CNT_EN
    logic [N*32-1:0] wc_a, wc_b;
`endif

    // Only the selected instance sees the FIFO contents; the other idles in ARB.
    assign empty_a = use_b ? '1 : fifo_empty;
    assign empty_b = use_b ? fifo_empty : '1;

    channel_data_merge_n #(.N_CH(N), .DATA_W(W), .MAX_BURST(16)) dut (
        .clk160(clk160), .reset(reset), .tds_mode(tds_mode), .enable(enable),
        .strip_linked(strip_linked), .pad_linked(pad_linked), .data_tran_stop(data_tran_stop),
        .channel_fifo_empty(empty_a), .channel_data(channel_data),
        .channel_data_read(read_a), .channel_linked(linked_a),
`ifdef CHANNEL_WORD_CNT_EN
        .cnt_clear(1'b0), .word_count(wc_a),
`endif
        .out_data(out_data_a), .out_channel(out_channel_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .dbg_state(state_a), .dbg_rr_ptr(rr_a)
    );

    channel_data_merge_n #(.N_CH(N), .DATA_W(W), .MAX_BURST(2)) dut_b2 (
        .clk160(clk160), .reset(reset), .tds_mode(tds_mode), .enable(enable),
        .strip_linked(strip_linked), .pad_linked(pad_linked), .data_tran_stop(data_tran_stop),
        .channel_fifo_empty(empty_b), .channel_data(channel_data),
        .channel_data_read(read_b), .channel_linked(linked_b),
`ifdef CHANNEL_WORD_CNT_EN
        .cnt_clear(1'b0), .word_count(wc_b),
`endif
        .out_data(out_data_b), .out_channel(out_channel_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .dbg_state(state_b), .dbg_rr_ptr(rr_b)
    );

    logic [N-1:0]   rd, linked;
    logic [W-1:0]   odata;
    logic [CHW-1:0] och, rr;
    logic           ovalid, ostate;
    assign rd     = use_b ? read_b : read_a;
    assign linked = use_b ? linked_b : linked_a;
    assign odata  = use_b ? out_data_b : out_data_a;
    assign och    = use_b ? out_channel_b : out_channel_a;
    assign ovalid = use_b ? out_valid_b : out_valid_a;
    assign ostate = use_b ? state_b : state_a;
    assign rr     = use_b ? rr_b : rr_a;

    // ---------------- FIFO models and scoreboard ----------------
    logic [W-1:0]  f0[$], f1[$], f2[$], f3[$];
    logic [XW-1:0] exp_q[$];
    logic [7:0]    test_id;
    int            popped[N];
    int            n_xfer;
    int            vectors;
    int            miscompares;

    logic           s_valid, s_ready;
    logic [W-1:0]   s_data;
    logic [CHW-1:0] s_ch;
    logic [N-1:0]   s_read;

    function automatic logic [W-1:0] word(input int ch, input int n);
        return {8'(8'hC0 + ch), 88'h0, test_id, 8'(ch), 8'(n)};
    endfunction

    function automatic int fsize(input int ch);
        case (ch)
            0: return f0.size();
            1: return f1.size();
            2: return f2.size();
            default: return f3.size();
        endcase
    endfunction

    function automatic logic [W-1:0] fhead(input int ch);
        case (ch)
            0: return f0[0];
            1: return f1[0];
            2: return f2[0];
            default: return f3[0];
        endcase
    endfunction

    task automatic fpush(input int ch, input logic [W-1:0] w);
        case (ch)
            0: f0.push_back(w);
            1: f1.push_back(w);
            2: f2.push_back(w);
            default: f3.push_back(w);
        endcase
    endtask

    task automatic fpop(input int ch);
        case (ch)
            0: void'(f0.pop_front());
            1: void'(f1.pop_front());
            2: void'(f2.pop_front());
            default: void'(f3.pop_front());
        endcase
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (fsize(i) == 0);
            channel_data[i*W +: W] = (fsize(i) != 0) ? fhead(i) : '0;
        end
    endtask

    task automatic load(input int ch, input int cnt);
        for (int n = 0; n < cnt; n++) fpush(ch, word(ch, n));
        refresh();
    endtask

    task automatic expect_w(input int ch, input int n);
        exp_q.push_back({6'b0, 2'(ch), word(ch, n)});
    endtask

    task automatic check_eq(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk160);
        s_valid = ovalid;
        s_ready = out_ready;
        s_data  = odata;
        s_ch    = och;
        s_read  = rd;
        @(posedge clk160);
        #1;
        check_eq("read_onehot0", XW'($onehot0(s_read)), XW'(1));
        for (int i = 0; i < N; i++) begin
            if (s_read[i]) begin
                fpop(i);
                popped[i]++;
            end
        end
        refresh();
        if (s_valid && s_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) check_eq("xfer_extra", {6'b0, s_ch, s_data}, '0);
            else check_eq("xfer", {6'b0, s_ch, s_data}, exp_q.pop_front());
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            tick();
            c++;
        end
        check_eq(tag, XW'(exp_q.size()), XW'(0));
        exp_q.delete();
        repeat (4) tick();
    endtask

    task automatic do_reset();
        f0.delete(); f1.delete(); f2.delete(); f3.delete();
        refresh();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) popped[i] = 0;
        n_xfer = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [W-1:0] hold_data;
        int c;
        vectors = 0; miscompares = 0; n_xfer = 0; test_id = 8'd0;
        reset = 1'b1; tds_mode = 1'b1; out_ready = 1'b1; use_b = 1'b0;
        enable = '0; strip_linked = '0; pad_linked = '0; data_tran_stop = '0;
        for (int i = 0; i < N; i++) popped[i] = 0;
        refresh();
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check_eq("rst_valid", XW'(ovalid), XW'(0));
        check_eq("rst_state", XW'(ostate), XW'(0));
        check_eq("rst_rr_ptr", XW'(rr), XW'(0));
        check_eq("rst_data", XW'(odata), XW'(0));
        check_eq("rst_channel", XW'(och), XW'(0));
        check_eq("rst_read", XW'(rd), XW'(0));

        // Round-robin, three words per channel.
        test_id = 8'd1;
        enable = 4'hF; strip_linked = 4'hF; pad_linked = 4'h0;
        for (int ch = 0; ch < N; ch++) begin
            load(ch, 3);
            for (int n = 0; n < 3; n++) expect_w(ch, n);
        end
        #1;
        check_eq("linked_strip", XW'(linked), XW'(4'hF));
        drain("rr_drain", 80);

        // Burst limit of 2 on the second instance.
        use_b = 1'b1;
        do_reset();
        test_id = 8'd2;
        load(0, 5); load(1, 1);
        expect_w(0, 0); expect_w(0, 1); expect_w(1, 0);
        expect_w(0, 2); expect_w(0, 3); expect_w(0, 4);
        drain("burst_drain", 60);
        check_eq("burst_rr_end", XW'(rr), XW'(1));
        use_b = 1'b0;

        // Backpressure mid-burst.
        do_reset();
        test_id = 8'd3;
        load(2, 6);
        for (int n = 0; n < 6; n++) expect_w(2, n);
        c = 0;
        while (n_xfer < 2 && c < 20) begin tick(); c++; end
        check_eq("bp_reached", XW'(n_xfer >= 2), XW'(1));
        out_ready = 1'b0;
        #1;
        hold_data = odata;
        check_eq("bp_valid_start", XW'(ovalid), XW'(1));
        repeat (4) begin
            tick();
            check_eq("bp_valid", XW'(s_valid), XW'(1));
            check_eq("bp_data", XW'(s_data), XW'(hold_data));
            check_eq("bp_read", XW'(s_read), XW'(0));
        end
        out_ready = 1'b1;
        drain("bp_drain", 40);

        // Pad mode with a link mask.
        do_reset();
        test_id = 8'd4;
        tds_mode = 1'b0; pad_linked = 4'b0101; strip_linked = 4'b1010;
        for (int ch = 0; ch < N; ch++) load(ch, 2);
        #1;
        check_eq("linked_pad", XW'(linked), XW'(4'b0101));
        expect_w(0, 0); expect_w(0, 1); expect_w(2, 0); expect_w(2, 1);
        drain("mask_drain", 40);
        check_eq("mask_ch1_left", XW'(fsize(1)), XW'(2));
        check_eq("mask_ch3_left", XW'(fsize(3)), XW'(2));
        tds_mode = 1'b1; strip_linked = 4'hF;

        // Transfer stop on channel 1 mid-burst.
        do_reset();
        test_id = 8'd5;
        load(1, 6); load(2, 6);
        expect_w(1, 0); expect_w(1, 1);
        for (int n = 0; n < 6; n++) expect_w(2, n);
        c = 0;
        while (popped[1] < 2 && c < 20) begin tick(); c++; end
        data_tran_stop = 4'b0010;
        drain("stop_drain", 40);
        check_eq("stop_ch1_pops", XW'(popped[1]), XW'(2));
        check_eq("stop_ch1_left", XW'(fsize(1)), XW'(4));
        data_tran_stop = '0;

        // Reset while a word is registered and stalled.
        do_reset();
        test_id = 8'd6;
        out_ready = 1'b0;
        load(3, 4);
        c = 0;
        while (!ovalid && c < 20) begin tick(); c++; end
        check_eq("rst2_valid_before", XW'(ovalid), XW'(1));
        load(0, 2);
        reset = 1'b1;
        tick();
        check_eq("rst2_read", XW'(s_read), XW'(0));
        reset = 1'b0;
        check_eq("rst2_valid", XW'(ovalid), XW'(0));
        check_eq("rst2_rr_ptr", XW'(rr), XW'(0));
        check_eq("rst2_state", XW'(ostate), XW'(0));
        out_ready = 1'b1;
        expect_w(0, 0); expect_w(0, 1);
        expect_w(3, 1); expect_w(3, 2); expect_w(3, 3);
        drain("rst2_drain", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
